// File: rtl/memory_arbiter_if.sv
// memory_arbiter_if: one client's request/response port on the memory arbiter
interface memory_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 24
) ();
    logic              req;
    logic [1:0]        func;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [3:0]        type_info;
    logic              done;
    logic [ADDR_W-1:0] rsp_addr;
    logic [DATA_W-1:0] rsp_data;

    modport master (output req, func, addr0, addr1, type_info, input done, rsp_addr, rsp_data);
    modport slave  (input req, func, addr0, addr1, type_info, output done, rsp_addr, rsp_data);
endinterface

// File: rtl/memory_arbiter.sv
// memory_arbiter: round-robin two-client arbiter serialising cell requests onto the memory unit
module memory_arbiter #(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 24,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    memory_arbiter_if.slave   a_if,
    memory_arbiter_if.slave   b_if,
    output logic              busy_o,
    output logic              err_o,
    output logic [1:0]        mem_func_o,
    output logic              mem_execute_o,
    output logic [ADDR_W-1:0] mem_addr0_o,
    output logic [ADDR_W-1:0] mem_addr1_o,
    output logic [3:0]        mem_type_o,
    input  logic              mem_ready_i,
    input  logic [ADDR_W-1:0] mem_addr_out_i,
    input  logic [DATA_W-1:0] mem_data_out_i
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ISSUE  = 3'd1;
    localparam logic [2:0] S_SETTLE = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;
    localparam logic [7:0] CNT_MAX  = 8'(TIMEOUT);

    logic [2:0]        state_q, state_d;
    logic              win_q, win_d;
    logic              last_q, last_d;
    logic              mask_q, mask_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] rsp_addr_q, rsp_addr_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic [1:0]        func_q, func_d;
    logic [ADDR_W-1:0] addr0_q, addr0_d;
    logic [ADDR_W-1:0] addr1_q, addr1_d;
    logic [3:0]        type_q, type_d;
    logic              elig_a, elig_b, grant, pick;

    // winner encoding: 0 = client A, 1 = client B; the mask hides last_q's client
    assign elig_a = a_if.req && !(mask_q && !last_q);
    assign elig_b = b_if.req && !(mask_q && last_q);
    assign grant  = (state_q == S_IDLE) && mem_ready_i && (elig_a || elig_b);
    assign pick   = (elig_a && elig_b) ? !last_q : elig_b;

    assign a_if.done     = (state_q == S_DONE) && !win_q;
    assign b_if.done     = (state_q == S_DONE) && win_q;
    assign a_if.rsp_addr = rsp_addr_q;
    assign b_if.rsp_addr = rsp_addr_q;
    assign a_if.rsp_data = rsp_data_q;
    assign b_if.rsp_data = rsp_data_q;
    assign busy_o        = state_q != S_IDLE;
    assign err_o         = err_q;
    assign mem_execute_o = state_q == S_ISSUE;
    assign mem_func_o    = func_q;
    assign mem_addr0_o   = addr0_q;
    assign mem_addr1_o   = addr1_q;
    assign mem_type_o    = type_q;

    // next-state: grant/latch in IDLE, timed wait for the memory handshake, done pulse
    always_comb begin
        state_d    = state_q;
        win_d      = win_q;
        last_d     = last_q;
        mask_d     = state_q == S_DONE;
        cnt_d      = cnt_q;
        err_d      = err_q;
        rsp_addr_d = rsp_addr_q;
        rsp_data_d = rsp_data_q;
        func_d     = func_q;
        addr0_d    = addr0_q;
        addr1_d    = addr1_q;
        type_d     = type_q;
        case (state_q)
            S_IDLE: if (grant) begin
                state_d = S_ISSUE;
                win_d   = pick;
                func_d  = pick ? b_if.func      : a_if.func;
                addr0_d = pick ? b_if.addr0     : a_if.addr0;
                addr1_d = pick ? b_if.addr1     : a_if.addr1;
                type_d  = pick ? b_if.type_info : a_if.type_info;
            end
            S_ISSUE:  state_d = S_SETTLE;
            S_SETTLE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q + 8'd1;
                if (mem_ready_i) begin
                    rsp_addr_d = mem_addr_out_i;
                    rsp_data_d = mem_data_out_i;
                    state_d    = S_DONE;
                end else if (cnt_d == CNT_MAX) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                last_d  = win_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // state registers; reset leaves B as last served so A wins the first tie
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            win_q      <= 1'b0;
            last_q     <= 1'b1;
            mask_q     <= 1'b0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            rsp_addr_q <= '0;
            rsp_data_q <= '0;
            func_q     <= '0;
            addr0_q    <= '0;
            addr1_q    <= '0;
            type_q     <= '0;
        end else begin
            state_q    <= state_d;
            win_q      <= win_d;
            last_q     <= last_d;
            mask_q     <= mask_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            rsp_addr_q <= rsp_addr_d;
            rsp_data_q <= rsp_data_d;
            func_q     <= func_d;
            addr0_q    <= addr0_d;
            addr1_q    <= addr1_d;
            type_q     <= type_d;
        end
    end
endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: scoreboard bench for memory_arbiter with a behavioural memory unit
module tb_memory_arbiter;
    localparam logic [1:0] F_SET_CAR  = 2'd0;
    localparam logic [1:0] F_SET_CDR  = 2'd1;
    localparam logic [1:0] F_CONS     = 2'd2;
    localparam logic [1:0] F_CONTENTS = 2'd3;
    localparam int TIMEOUT = 255;

    typedef struct {
        bit          who;
        bit          chk_addr;
        logic [9:0]  addr;
        bit          chk_data;
        logic [23:0] data;
        bit          err;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    memory_arbiter_if #(.ADDR_W(10), .DATA_W(24)) a_if ();
    memory_arbiter_if #(.ADDR_W(10), .DATA_W(24)) b_if ();

    logic        busy, err, mem_execute, mem_ready;
    logic [1:0]  mem_func;
    logic [9:0]  mem_addr0, mem_addr1, mem_addr_out;
    logic [3:0]  mem_type;
    logic [23:0] mem_data_out;

    memory_arbiter #(.ADDR_W(10), .DATA_W(24), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .a_if(a_if), .b_if(b_if),
        .busy_o(busy), .err_o(err), .mem_func_o(mem_func), .mem_execute_o(mem_execute),
        .mem_addr0_o(mem_addr0), .mem_addr1_o(mem_addr1), .mem_type_o(mem_type),
        .mem_ready_i(mem_ready), .mem_addr_out_i(mem_addr_out), .mem_data_out_i(mem_data_out)
    );

    int n_chk = 0;
    int n_fail = 0;
    exp_t exp_q[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    // behavioural memory unit: 1-cycle ops ready 2 edges after execute, GET_CONTENTS 4
    int          init_cnt, mcnt;
    bit          hang = 1'b0;
    logic [1:0]  pf;
    logic [9:0]  pa0, pa1, free_ptr;
    logic [3:0]  pt;
    logic [23:0] cells [1024];
    always @(posedge clk) begin
        if (rst) begin
            mem_ready    <= 1'b0;
            init_cnt     <= 4;
            mcnt         <= 0;
            free_ptr     <= 10'h100;
            mem_addr_out <= '0;
            mem_data_out <= '0;
            cells[5]     <= {4'h3, 10'h00A, 10'h00B};
        end else if (init_cnt > 0) begin
            init_cnt  <= init_cnt - 1;
            mem_ready <= init_cnt == 1;
        end else if (mem_execute) begin
            mem_ready <= 1'b0;
            mcnt      <= (mem_func == F_CONTENTS) ? 3 : 1;
            pf        <= mem_func;
            pa0       <= mem_addr0;
            pa1       <= mem_addr1;
            pt        <= mem_type;
        end else if (mcnt > 0 && !hang) begin
            mcnt <= mcnt - 1;
            if (mcnt == 1) begin
                mem_ready    <= 1'b1;
                mem_addr_out <= pa0;
                if (pf == F_CONTENTS) mem_data_out <= cells[pa0];
                else if (pf == F_CONS) begin
                    cells[free_ptr] <= {pt, pa0, pa1};
                    mem_addr_out    <= free_ptr;
                    mem_data_out    <= {pt, pa0, pa1};
                    free_ptr        <= free_ptr + 10'd1;
                end else if (pf == F_SET_CAR) cells[pa0][19:10] <= pa1;
                else cells[pa0][9:0] <= pa1;
            end
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // monitor: execute must be single-cycle; every done pops and checks the scoreboard
    bit prev_exec = 1'b0;
    int last_exec = 0;
    int exec_n = 0;
    int exec_cyc[$];
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_execute) begin
                check("exec_single_cycle", 32'(prev_exec), 0);
                last_exec <= cyc;
                exec_n    <= exec_n + 1;
                exec_cyc.push_back(cyc);
            end
            prev_exec <= mem_execute;
            if (a_if.done || b_if.done) begin
                check("done_expected", 32'(exp_q.size() != 0), 1);
                check("done_one_client", 32'(a_if.done & b_if.done), 0);
                if (exp_q.size() != 0) begin
                    check("done_client", 32'(b_if.done), 32'(exp_q[0].who));
                    if (exp_q[0].chk_addr) check("rsp_addr", 32'(a_if.rsp_addr), 32'(exp_q[0].addr));
                    if (exp_q[0].chk_data) check("rsp_data", 32'(a_if.rsp_data), 32'(exp_q[0].data));
                    check("b_rsp_shared", 32'(b_if.rsp_data), 32'(a_if.rsp_data));
                    check("err_at_done", 32'(err), 32'(exp_q[0].err));
                    check("latency", cyc - last_exec, exp_q[0].lat);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic expect_rsp(input bit who, input bit ca, input logic [9:0] ad,
                              input bit cd, input logic [23:0] d, input bit e, input int lat);
        exp_q.push_back('{who, ca, ad, cd, d, e, lat});
    endtask

    task automatic drive(input bit who, input logic r, input logic [1:0] f,
                         input logic [9:0] a0, input logic [9:0] a1, input logic [3:0] t);
        if (!who) begin
            a_if.req = r; a_if.func = f; a_if.addr0 = a0; a_if.addr1 = a1; a_if.type_info = t;
        end else begin
            b_if.req = r; b_if.func = f; b_if.addr0 = a0; b_if.addr1 = a1; b_if.type_info = t;
        end
    endtask

    // client: request reps times back to back, hold req extra cycles after last done, then drop
    task automatic client(input bit who, input logic [1:0] f, input logic [9:0] a0,
                          input logic [9:0] a1, input logic [3:0] t, input int reps, input int extra);
        bit got;
        for (int r = 0; r < reps; r++) begin
            drive(who, 1'b1, f, a0, a1, t);
            got = 1'b0;
            for (int k = 0; k < 1000 && !got; k++) begin
                @(negedge clk);
                got = who ? b_if.done : a_if.done;
            end
            check(who ? "b_done_wait" : "a_done_wait", 32'(got), 1);
            @(posedge clk); #1;
        end
        repeat (extra) begin @(posedge clk); #1; end
        drive(who, 1'b0, f, a0, a1, t);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(0, 1'b0, 2'd0, 10'd0, 10'd0, 4'd0);
        drive(1, 1'b0, 2'd0, 10'd0, 10'd0, 4'd0);
        @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_execute", 32'(mem_execute), 0);
        check("rst_a_done", 32'(a_if.done), 0);
        check("rst_b_done", 32'(b_if.done), 0);
        check("rst_err", 32'(err), 0);
        check("rst_rsp_addr", 32'(a_if.rsp_addr), 0);
        check("rst_rsp_data", 32'(a_if.rsp_data), 0);
        check("rst_mem_func", 32'(mem_func), 0);
        check("rst_mem_addr0", 32'(mem_addr0), 0);
        check("rst_mem_addr1", 32'(mem_addr1), 0);
        check("rst_mem_type", 32'(mem_type), 0);
        rst = 1'b0;
    endtask

    task automatic wait_ready();
        for (int k = 0; k < 50 && mem_ready !== 1'b1; k++) @(negedge clk);
        check("mem_init_ready", 32'(mem_ready), 1);
    endtask

    task automatic drain();
        for (int k = 0; k < 2000 && exp_q.size() != 0; k++) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1);
    end

    initial begin
        logic [23:0] orig;
        bit got;
        int n0, i0;
        orig = {4'h3, 10'h00A, 10'h00B};
        drive(0, 1'b0, 2'd0, 10'd0, 10'd0, 4'd0);
        drive(1, 1'b0, 2'd0, 10'd0, 10'd0, 4'd0);

        // single read, then SET_CDR and read back
        do_reset();
        wait_ready();
        expect_rsp(0, 1, 10'h005, 1, orig, 0, 5);
        client(0, F_CONTENTS, 10'h005, 10'h000, 4'h0, 1, 0);
        expect_rsp(0, 1, 10'h005, 0, 24'h0, 0, 3);
        client(0, F_SET_CDR, 10'h005, 10'h033, 4'h0, 1, 0);
        expect_rsp(0, 1, 10'h005, 1, {4'h3, 10'h00A, 10'h033}, 0, 5);
        client(0, F_CONTENTS, 10'h005, 10'h000, 4'h0, 1, 0);
        drain();

        // tie: A wins first after reset, B gets the next allocated cell
        do_reset();
        wait_ready();
        expect_rsp(0, 1, 10'h100, 1, {4'h1, 10'h001, 10'h002}, 0, 3);
        expect_rsp(1, 1, 10'h101, 1, {4'h2, 10'h003, 10'h004}, 0, 3);
        fork
            client(0, F_CONS, 10'h001, 10'h002, 4'h1, 1, 0);
            client(1, F_CONS, 10'h003, 10'h004, 4'h2, 1, 0);
        join
        drain();

        // fairness: A holds req, B joins mid-transaction; grants alternate 5 cycles apart
        do_reset();
        wait_ready();
        i0 = exec_cyc.size();
        expect_rsp(0, 1, 10'h100, 1, {4'h1, 10'h001, 10'h002}, 0, 3);
        expect_rsp(1, 1, 10'h101, 1, {4'h2, 10'h003, 10'h004}, 0, 3);
        expect_rsp(0, 1, 10'h102, 1, {4'h1, 10'h001, 10'h002}, 0, 3);
        expect_rsp(1, 1, 10'h103, 1, {4'h2, 10'h003, 10'h004}, 0, 3);
        fork
            client(0, F_CONS, 10'h001, 10'h002, 4'h1, 2, 0);
            begin repeat (2) @(posedge clk); #1; client(1, F_CONS, 10'h003, 10'h004, 4'h2, 2, 0); end
        join
        drain();
        check("fair_exec_count", exec_cyc.size() - i0, 4);
        for (int k = 0; k < 3; k++) check("fair_grant_gap", exec_cyc[i0+k+1] - exec_cyc[i0+k], 5);

        // mask: req held one cycle past done gives no re-issue; held on gives a grant a cycle later
        do_reset();
        wait_ready();
        n0 = exec_n;
        expect_rsp(0, 1, 10'h005, 1, orig, 0, 5);
        client(0, F_CONTENTS, 10'h005, 10'h000, 4'h0, 1, 1);
        repeat (12) @(negedge clk);
        check("mask_single_issue", exec_n - n0, 1);
        i0 = exec_cyc.size();
        expect_rsp(0, 1, 10'h005, 1, orig, 0, 5);
        expect_rsp(0, 1, 10'h005, 1, orig, 0, 5);
        client(0, F_CONTENTS, 10'h005, 10'h000, 4'h0, 2, 0);
        drain();
        check("mask_regrant_gap", exec_cyc[i0+1] - exec_cyc[i0], 8);

        // timeout: memory never returns ready; err sticky, rsp unchanged
        do_reset();
        wait_ready();
        expect_rsp(0, 1, 10'h005, 1, orig, 0, 5);
        client(0, F_CONTENTS, 10'h005, 10'h000, 4'h0, 1, 0);
        drain();
        hang = 1'b1;
        expect_rsp(0, 1, 10'h005, 1, orig, 1, TIMEOUT + 2);
        client(0, F_CONTENTS, 10'h007, 10'h000, 4'h0, 1, 0);
        drain();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("err_sticky", 32'(err), 1);
        end
        hang = 1'b0;

        // reset during SETTLE, then a fresh request completes
        do_reset();
        wait_ready();
        expect_rsp(0, 1, 10'h005, 1, orig, 0, 5);
        client(0, F_CONTENTS, 10'h005, 10'h000, 4'h0, 1, 0);
        drain();
        drive(0, 1'b1, F_CONTENTS, 10'h005, 10'h000, 4'h0);
        got = 1'b0;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge clk);
            got = mem_execute;
        end
        check("mid_exec_seen", 32'(got), 1);
        @(posedge clk); #1;
        check("mid_settle_busy", 32'(busy), 1);
        do_reset();
        repeat (3) @(negedge clk);
        check("mid_idle_after_rst", 32'(busy), 0);
        wait_ready();
        expect_rsp(0, 1, 10'h005, 1, orig, 0, 5);
        client(0, F_CONTENTS, 10'h005, 10'h000, 4'h0, 1, 0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Two-client arbiter sitting directly upstream of the memory unit. It accepts cell requests from two clients, A (evaluator) and B (reader/loader). Requests are CONS, GET_CONTENTS, SET_CAR and SET_CDR. The arbiter serialises them onto the memory unit's single func/execute port, tracks the unit's is_ready handshake, captures addr_out/data_out, and returns them to the winning client with a one-cycle done pulse.

## Interface
- ADDR_W, 10, cell address width; matches `memory_addr_width`.
- DATA_W, 24, cell word width; matches `memory_data_width` ({type[3:0], car, cdr}).
- TIMEOUT, 255, maximum WAIT_RDY cycles before an error is flagged; fits in 8 bits.
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- a_req, b_req  in  1  level request from client A / B.
- a_func, b_func  in  2  memory function code (`SET_CAR`, `SET_CDR`, `GET_CONS`, `GET_CONTENTS`).
- a_addr0, a_addr1, b_addr0, b_addr1  in  ADDR_W  operand addresses.
- a_type, b_type  in  4  type_info for cons.
- a_done, b_done  out  1  one-cycle completion pulse to the served client.
- rsp_addr  out  ADDR_W  captured mem addr_out.
- rsp_data  out  DATA_W  captured mem data_out.
- busy  out  1  high in every state except IDLE.
- err  out  1  sticky timeout flag; cleared only by rst.
- mem_func  out  2  to memory unit func.
- mem_execute  out  1  to memory unit execute.
- mem_addr0, mem_addr1  out  ADDR_W  to memory unit.
- mem_type  out  4  to memory unit type_info.
- mem_ready  in  1  memory unit is_ready.
- mem_addr_out  in  ADDR_W  memory unit addr_out.
- mem_data_out  in  DATA_W  memory unit data_out.

## Operation
- States:
  - IDLE → ISSUE → SETTLE → WAIT_RDY → DONE → IDLE.
  - WAIT_RDY → DONE also on timeout.
- Client rules:
  - A client holds req and operands stable until its done pulse.
  - It drops req in the cycle after done, or keeps req high to request again.
- IDLE:
  - Grant only if mem_ready=1 and at least one eligible req.
  - Eligible means req high and the client is not masked.
  - On grant, latch func/addr0/addr1/type into the mem_* registers, record the winner, go ISSUE.
- Arbitration is round-robin:
  - If both are eligible, the client not served last wins.
  - last_served resets to B, so A wins the first tie.
- Masking: the client served by the immediately preceding DONE is masked for the one IDLE cycle after DONE.
- ISSUE: mem_execute=1 for exactly this cycle. Go SETTLE.
- SETTLE: ignore mem_ready (the memory unit holds it low after execute). Clear the timeout counter. Go WAIT_RDY.
- WAIT_RDY:
  - On mem_ready=1: capture rsp_addr←mem_addr_out and rsp_data←mem_data_out, go DONE.
  - Otherwise increment the counter.
  - If the counter reaches TIMEOUT: set err, leave rsp_* unchanged, go DONE.
- DONE: pulse the winner's done, update last_served, go IDLE.
- rsp_* hold their value until the next capture and are shared by both clients.
- mem_func/addr/type hold their last value outside ISSUE; only mem_execute qualifies them.
- Unknown func codes are passed through unchanged; the arbiter does not decode func.

## Timing
- Reset values:
  - State IDLE.
  - All outputs 0: mem_execute, done, busy, err, rsp_addr, rsp_data, mem_func, mem_addr0/1, mem_type.
  - Timeout counter 0, last_served=B, no mask.
- Latency, with grant in IDLE at cycle T (current memory unit):
  - SET_CAR/SET_CDR: mem_ready returns at T+3, done at T+4.
  - GET_CONS: mem_ready returns at T+3, done at T+4; rsp_addr is the newly allocated cell.
  - GET_CONTENTS: mem_ready returns at T+5, done at T+6; rsp_data is the cell word.
- Minimum spacing between consecutive grants is 5 cycles (DONE→IDLE→ISSUE).
- mem_ready=0 in IDLE (memory still initialising or busy) stalls the grant indefinitely with no timeout.
- req dropped after grant does not abort; the transaction completes and done still pulses.
- rst asserted mid-transaction returns the arbiter to IDLE next edge with mem_execute=0.
  - The memory unit must be reset together with the arbiter; the arbiter does not recover a half-finished memory transaction.

## Test plan
- Single read: after the memory unit initialises, A requests GET_CONTENTS addr0=0x005 holding 0x3_00A_00B.
  - Required: mem_execute high exactly one cycle; a_done 6 cycles after grant; rsp_data=0x300A00B; b_done never pulses.
- Tie arbitration: A and B raise GET_CONS in the same cycle.
  - Required: A is served first, then B.
  - B's rsp_addr equals A's rsp_addr+1.
- Fairness: A holds req continuously and B raises req during A's transaction.
  - Required: grants alternate A, B, A, B over 4 transactions; no client is served twice in a row while the other waits.
- Mask: A keeps a_req high for one cycle after a_done.
  - Required: no duplicate issue in that IDLE cycle; the next A grant comes only if a_req is still high a cycle later.
- Timeout: tie mem_ready low after ISSUE.
  - Required: err=1 and a_done pulse after TIMEOUT WAIT_RDY cycles; rsp_* unchanged; err stays 1 until rst.
- Reset mid-read: assert rst in SETTLE.
  - Required: next cycle busy=0, mem_execute=0, err=0, rsp_*=0; a fresh request after reset completes normally.
